// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// control_sequencer
// Hardwired multi-cycle control unit for the 32-bit datapath. Sequences the
// instruction fetch (T0, T1, optional memory wait states, T2), decodes the
// opcode in T3 and then steps through the execute cycles for in, out, jr,
// jal, branch, nop and halt. Supports an inport stall handshake and a
// halt/resume mode.
//
// Ports
//   Clock          system clock, rising edge
//   clear          synchronous active-high reset
//   ir_opcode      IR[31:27], valid from T3 onwards
//   con_ff_bit     branch condition flip-flop
//   inport_valid   external device has input data
//   run_req        resume request, only honoured while halted
//   PCout..Mem_enable512x32   fetch / datapath controls
//   Gra..Cout      execute controls
//   alu_op         ALU opcode (zero except in the branch target add)
//   Run            high while executing, low while halted
//   illegal_op     one-cycle pulse in T3 on an undefined opcode
//   state_out      current state encoding, for debug
//
// Controls are a Moore decode of the state register. Two states also look
// at a registered datapath signal: T3 decodes the freshly loaded IR (and the
// inport handshake for an immediate in), B6 gates PCin with the CON FF.
module control_sequencer #(
    parameter int unsigned              OPCODE_WIDTH = 5,
    parameter int unsigned              MEM_WAIT     = 0,
    parameter logic [OPCODE_WIDTH-1:0]  OP_ADD       = 5'b00011,
    parameter logic [OPCODE_WIDTH-1:0]  OP_BR        = 5'b10011,
    parameter logic [OPCODE_WIDTH-1:0]  OP_JR        = 5'b10100,
    parameter logic [OPCODE_WIDTH-1:0]  OP_JAL       = 5'b10101,
    parameter logic [OPCODE_WIDTH-1:0]  OP_IN        = 5'b10110,
    parameter logic [OPCODE_WIDTH-1:0]  OP_OUT       = 5'b10111,
    parameter logic [OPCODE_WIDTH-1:0]  OP_NOP       = 5'b11000,
    parameter logic [OPCODE_WIDTH-1:0]  OP_HALT      = 5'b11001
) (
    input  logic                    Clock,
    input  logic                    clear,
    input  logic [OPCODE_WIDTH-1:0] ir_opcode,
    input  logic                    con_ff_bit,
    input  logic                    inport_valid,
    input  logic                    run_req,
    output logic                    PCout,
    output logic                    IncPC,
    output logic                    MARin,
    output logic                    Zin,
    output logic                    Zlo_out,
    output logic                    PCin,
    output logic                    MDRin,
    output logic                    MDRout,
    output logic                    IRin,
    output logic                    Mem_read,
    output logic                    Mem_enable512x32,
    output logic                    Gra,
    output logic                    Grb,
    output logic                    Rin,
    output logic                    Rout,
    output logic                    Inport_out,
    output logic                    outport_in,
    output logic                    CONin,
    output logic                    Yin,
    output logic                    Cout,
    output logic [OPCODE_WIDTH-1:0] alu_op,
    output logic                    Run,
    output logic                    illegal_op,
    output logic [4:0]              state_out
);

    localparam int unsigned WAIT_W = 3;
    // First value of the wait counter; T1W then lasts exactly MEM_WAIT cycles.
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (MEM_WAIT == 0) ? '0 : WAIT_W'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_RST = 5'd0,
        S_T0  = 5'd1,
        S_T1  = 5'd2,
        S_T1W = 5'd3,
        S_T2  = 5'd4,
        S_T3  = 5'd5,
        S_INW = 5'd6,
        S_IN3 = 5'd7,
        S_J4  = 5'd8,
        S_B4  = 5'd9,
        S_B5  = 5'd10,
        S_B6  = 5'd11,
        S_HLT = 5'd12
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    // State and wait-counter registers; clear overrides everything.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= S_RST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d          = state_q;
        wait_d           = wait_q;
        PCout            = 1'b0;
        IncPC            = 1'b0;
        MARin            = 1'b0;
        Zin              = 1'b0;
        Zlo_out          = 1'b0;
        PCin             = 1'b0;
        MDRin            = 1'b0;
        MDRout           = 1'b0;
        IRin             = 1'b0;
        Mem_read         = 1'b0;
        Mem_enable512x32 = 1'b0;
        Gra              = 1'b0;
        Grb              = 1'b0;
        Rin              = 1'b0;
        Rout             = 1'b0;
        Inport_out       = 1'b0;
        outport_in       = 1'b0;
        CONin            = 1'b0;
        Yin              = 1'b0;
        Cout             = 1'b0;
        alu_op           = '0;
        Run              = 1'b1;
        illegal_op       = 1'b0;

        case (state_q)
            S_RST: state_d = S_T0;

            // MAR <- PC, Z <- PC + 1
            S_T0: begin
                PCout   = 1'b1;
                IncPC   = 1'b1;
                MARin   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end

            // PC <- Z, start the memory read into MDR
            S_T1: begin
                Zlo_out          = 1'b1;
                PCin             = 1'b1;
                Mem_read         = 1'b1;
                Mem_enable512x32 = 1'b1;
                MDRin            = 1'b1;
                if (MEM_WAIT != 0) begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_T1W;
                end else begin
                    state_d = S_T2;
                end
            end

            // Hold the read while the memory is slow
            S_T1W: begin
                Mem_read         = 1'b1;
                Mem_enable512x32 = 1'b1;
                MDRin            = 1'b1;
                if (wait_q == '0) begin
                    state_d = S_T2;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            // IR <- MDR
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end

            // Decode and first execute step
            S_T3: begin
                state_d = S_T0;
                case (ir_opcode)
                    OP_IN: begin
                        if (inport_valid) begin
                            Gra        = 1'b1;
                            Rin        = 1'b1;
                            Inport_out = 1'b1;
                        end else begin
                            state_d = S_INW;
                        end
                    end
                    OP_OUT: begin
                        Gra        = 1'b1;
                        Rout       = 1'b1;
                        outport_in = 1'b1;
                    end
                    OP_JR: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        PCin = 1'b1;
                    end
                    // Link: R[rb] <- PC
                    OP_JAL: begin
                        Grb     = 1'b1;
                        Rin     = 1'b1;
                        PCout   = 1'b1;
                        state_d = S_J4;
                    end
                    // Evaluate the branch condition into the CON FF
                    OP_BR: begin
                        Gra     = 1'b1;
                        Rout    = 1'b1;
                        CONin   = 1'b1;
                        state_d = S_B4;
                    end
                    OP_NOP:  state_d = S_T0;
                    OP_HALT: state_d = S_HLT;
                    default: illegal_op = 1'b1;
                endcase
            end

            // Stall until the input device has data
            S_INW: begin
                if (inport_valid) begin
                    state_d = S_IN3;
                end
            end

            S_IN3: begin
                Gra        = 1'b1;
                Rin        = 1'b1;
                Inport_out = 1'b1;
                state_d    = S_T0;
            end

            // PC <- R[ra]
            S_J4: begin
                Gra     = 1'b1;
                Rout    = 1'b1;
                PCin    = 1'b1;
                state_d = S_T0;
            end

            // Y <- PC
            S_B4: begin
                PCout   = 1'b1;
                Yin     = 1'b1;
                state_d = S_B5;
            end

            // Z <- Y + sign-extended offset
            S_B5: begin
                Cout    = 1'b1;
                Zin     = 1'b1;
                alu_op  = OP_ADD;
                state_d = S_B6;
            end

            // Only load the target into PC when the branch is taken
            S_B6: begin
                Zlo_out = 1'b1;
                PCin    = con_ff_bit;
                state_d = S_T0;
            end

            S_HLT: begin
                Run = 1'b0;
                if (run_req) begin
                    state_d = S_T0;
                end
            end

            default: state_d = S_RST;
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
// Bench for control_sequencer: two instances (no memory wait, two wait
// states) take turns running directed and random instruction streams while
// the other is held in clear. A per-instruction cycle script gives the
// expected control word for every cycle.
module tb_control_sequencer;

    localparam logic [4:0] O_ADD  = 5'b00011;
    localparam logic [4:0] O_BR   = 5'b10011;
    localparam logic [4:0] O_JR   = 5'b10100;
    localparam logic [4:0] O_JAL  = 5'b10101;
    localparam logic [4:0] O_IN   = 5'b10110;
    localparam logic [4:0] O_OUT  = 5'b10111;
    localparam logic [4:0] O_NOP  = 5'b11000;
    localparam logic [4:0] O_HALT = 5'b11001;
    localparam int MW_A = 0;
    localparam int MW_B = 2;

    // Bit positions of the packed control word
    localparam logic [26:0] M_PCOUT  = 27'd1 << 0;
    localparam logic [26:0] M_INCPC  = 27'd1 << 1;
    localparam logic [26:0] M_MARIN  = 27'd1 << 2;
    localparam logic [26:0] M_ZIN    = 27'd1 << 3;
    localparam logic [26:0] M_ZLO    = 27'd1 << 4;
    localparam logic [26:0] M_PCIN   = 27'd1 << 5;
    localparam logic [26:0] M_MDRIN  = 27'd1 << 6;
    localparam logic [26:0] M_MDROUT = 27'd1 << 7;
    localparam logic [26:0] M_IRIN   = 27'd1 << 8;
    localparam logic [26:0] M_MREAD  = 27'd1 << 9;
    localparam logic [26:0] M_MEN    = 27'd1 << 10;
    localparam logic [26:0] M_GRA    = 27'd1 << 11;
    localparam logic [26:0] M_GRB    = 27'd1 << 12;
    localparam logic [26:0] M_RIN    = 27'd1 << 13;
    localparam logic [26:0] M_ROUT   = 27'd1 << 14;
    localparam logic [26:0] M_INOUT  = 27'd1 << 15;
    localparam logic [26:0] M_OUTIN  = 27'd1 << 16;
    localparam logic [26:0] M_CONIN  = 27'd1 << 17;
    localparam logic [26:0] M_YIN    = 27'd1 << 18;
    localparam logic [26:0] M_COUT   = 27'd1 << 19;
    localparam logic [26:0] M_ALUADD = 27'(O_ADD) << 20;
    localparam logic [26:0] M_RUN    = 27'd1 << 25;
    localparam logic [26:0] M_ILL    = 27'd1 << 26;

    localparam logic [26:0] F_T0 = M_RUN | M_PCOUT | M_INCPC | M_MARIN | M_ZIN;
    localparam logic [26:0] F_T1 = M_RUN | M_ZLO | M_PCIN | M_MREAD | M_MEN | M_MDRIN;
    localparam logic [26:0] F_W  = M_RUN | M_MREAD | M_MEN | M_MDRIN;
    localparam logic [26:0] F_T2 = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [26:0] X_IN = M_RUN | M_GRA | M_RIN | M_INOUT;

    logic        Clock = 1'b0;
    logic        clr_a, clr_b;
    logic [4:0]  ir_opcode;
    logic        con_ff_bit, inport_valid, run_req;
    wire  [26:0] v_a, v_b;
    wire  [4:0]  st_a, st_b;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          len_ctr = 0;
    int          len_seen = 0;
    int          pending_len = 0;
    int          mw = MW_A;
    logic        sel = 1'b0;
    logic        exp_valid = 1'b0;
    logic [26:0] exp_vec = M_RUN;

    always #5 Clock = ~Clock;

    control_sequencer #(.MEM_WAIT(MW_A)) dut_a (
        .Clock(Clock), .clear(clr_a), .ir_opcode(ir_opcode), .con_ff_bit(con_ff_bit),
        .inport_valid(inport_valid), .run_req(run_req),
        .PCout(v_a[0]), .IncPC(v_a[1]), .MARin(v_a[2]), .Zin(v_a[3]), .Zlo_out(v_a[4]),
        .PCin(v_a[5]), .MDRin(v_a[6]), .MDRout(v_a[7]), .IRin(v_a[8]), .Mem_read(v_a[9]),
        .Mem_enable512x32(v_a[10]), .Gra(v_a[11]), .Grb(v_a[12]), .Rin(v_a[13]),
        .Rout(v_a[14]), .Inport_out(v_a[15]), .outport_in(v_a[16]), .CONin(v_a[17]),
        .Yin(v_a[18]), .Cout(v_a[19]), .alu_op(v_a[24:20]), .Run(v_a[25]),
        .illegal_op(v_a[26]), .state_out(st_a)
    );

    control_sequencer #(.MEM_WAIT(MW_B)) dut_b (
        .Clock(Clock), .clear(clr_b), .ir_opcode(ir_opcode), .con_ff_bit(con_ff_bit),
        .inport_valid(inport_valid), .run_req(run_req),
        .PCout(v_b[0]), .IncPC(v_b[1]), .MARin(v_b[2]), .Zin(v_b[3]), .Zlo_out(v_b[4]),
        .PCin(v_b[5]), .MDRin(v_b[6]), .MDRout(v_b[7]), .IRin(v_b[8]), .Mem_read(v_b[9]),
        .Mem_enable512x32(v_b[10]), .Gra(v_b[11]), .Grb(v_b[12]), .Rin(v_b[13]),
        .Rout(v_b[14]), .Inport_out(v_b[15]), .outport_in(v_b[16]), .CONin(v_b[17]),
        .Yin(v_b[18]), .Cout(v_b[19]), .alu_op(v_b[24:20]), .Run(v_b[25]),
        .illegal_op(v_b[26]), .state_out(st_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Compare process: active instance against the script, idle one against reset.
    // Also measures instruction length as the distance between T0 cycles.
    always @(negedge Clock) begin
        cyc++;
        if (exp_valid) begin
            check(sel ? "ctrl_b" : "ctrl_a", 32'(sel ? v_b : v_a), 32'(exp_vec));
            check(sel ? "idle_a" : "idle_b", 32'(sel ? v_a : v_b), 32'(M_RUN));
            if (((sel ? v_b : v_a) & M_INCPC) != '0) begin
                len_seen = len_ctr;
                len_ctr  = 1;
            end else begin
                len_ctr++;
            end
        end
    end

    task automatic noise();
        ir_opcode    = 5'($urandom);
        con_ff_bit   = 1'($urandom);
        inport_valid = 1'($urandom);
        run_req      = 1'($urandom);
        if (sel) clr_b = 1'b0;
        else     clr_a = 1'b0;
    endtask

    task automatic set_clear(input logic v);
        if (sel) clr_b = v;
        else     clr_a = v;
    endtask

    task automatic step(input logic [26:0] e);
        exp_vec = e;
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch();
        noise(); step(F_T0);
        if (pending_len != 0) check("instr_len", 32'(len_seen), 32'(pending_len));
        noise(); step(F_T1);
        for (int i = 0; i < mw; i++) begin
            noise(); step(F_W);
        end
        noise(); step(F_T2);
    endtask

    // One instruction: fetch, then the execute cycles for op. want_len > 0
    // pins the length to a literal, otherwise the model's own count is used.
    task automatic instr(input logic [4:0] op, input logic pv, input int stall,
                         input logic con, input int hw, input int want_len);
        int len;
        fetch();
        noise();
        ir_opcode = op;
        len = 4 + mw;
        case (op)
            O_IN: begin
                inport_valid = pv;
                if (pv) begin
                    step(X_IN);
                end else begin
                    step(M_RUN);
                    for (int k = 0; k < stall; k++) begin
                        noise(); inport_valid = (k == stall - 1); step(M_RUN);
                    end
                    noise(); step(X_IN);
                    len += 1 + stall;
                end
            end
            O_OUT: step(M_RUN | M_GRA | M_ROUT | M_OUTIN);
            O_JR:  step(M_RUN | M_GRA | M_ROUT | M_PCIN);
            O_JAL: begin
                step(M_RUN | M_GRB | M_RIN | M_PCOUT);
                noise(); step(M_RUN | M_GRA | M_ROUT | M_PCIN);
                len += 1;
            end
            O_BR: begin
                step(M_RUN | M_GRA | M_ROUT | M_CONIN);
                noise(); step(M_RUN | M_PCOUT | M_YIN);
                noise(); step(M_RUN | M_COUT | M_ZIN | M_ALUADD);
                noise(); con_ff_bit = con; step(M_RUN | M_ZLO | (con ? M_PCIN : '0));
                len += 3;
            end
            O_NOP: step(M_RUN);
            O_HALT: begin
                step(M_RUN);
                for (int k = 0; k < hw; k++) begin
                    noise(); run_req = (k == hw - 1); step('0);
                end
                len += hw;
            end
            default: step(M_RUN | M_ILL);
        endcase
        pending_len = (want_len > 0) ? want_len : len;
    endtask

    // Branch interrupted by clear during B5
    task automatic br_with_clear();
        fetch();
        noise(); ir_opcode = O_BR; step(M_RUN | M_GRA | M_ROUT | M_CONIN);
        noise(); step(M_RUN | M_PCOUT | M_YIN);
        noise(); set_clear(1'b1); run_req = 1'b1; step(M_RUN | M_COUT | M_ZIN | M_ALUADD);
        noise(); step(M_RUN);
        pending_len = 0;
    endtask

    // Halt where clear and run_req arrive together: clear must win
    task automatic halt_with_clear();
        fetch();
        noise(); ir_opcode = O_HALT; step(M_RUN);
        noise(); run_req = 1'b0; step('0);
        noise(); run_req = 1'b1; set_clear(1'b1); step('0);
        noise(); step(M_RUN);
        pending_len = 0;
    endtask

    function automatic logic is_defined(input logic [4:0] op);
        return op inside {O_BR, O_JR, O_JAL, O_IN, O_OUT, O_NOP, O_HALT};
    endfunction

    task automatic rand_instr();
        logic [4:0] op;
        int r;
        r = int'($urandom_range(0, 8));
        case (r)
            0: op = O_IN;
            1: op = O_OUT;
            2: op = O_JR;
            3: op = O_JAL;
            4: op = O_BR;
            5: op = O_NOP;
            6: op = O_HALT;
            default: begin
                op = 5'($urandom);
                while (is_defined(op)) op = 5'($urandom);
            end
        endcase
        instr(op, 1'($urandom), int'($urandom_range(1, 4)), 1'($urandom),
              int'($urandom_range(1, 5)), 0);
    endtask

    task automatic switch_to_b();
        noise(); clr_a = 1'b1; step(F_T0);
        if (pending_len != 0) check("instr_len", 32'(len_seen), 32'(pending_len));
        sel = 1'b1;
        mw  = MW_B;
        noise(); step(M_RUN);
        pending_len = 0;
    endtask

    initial begin
        clr_a = 1'b1; clr_b = 1'b1;
        ir_opcode = '0; con_ff_bit = 1'b0; inport_valid = 1'b0; run_req = 1'b0;
        @(posedge Clock);
        #1;
        exp_valid = 1'b1;
        step(M_RUN);
        noise(); step(M_RUN);

        // Instance without wait states
        instr(O_IN,   1'b1, 0, 1'b0, 0, 4);
        instr(O_IN,   1'b0, 3, 1'b0, 0, 8);
        instr(O_JR,   1'b0, 0, 1'b0, 0, 4);
        instr(O_JAL,  1'b0, 0, 1'b0, 0, 5);
        instr(O_BR,   1'b0, 0, 1'b1, 0, 7);
        instr(O_BR,   1'b0, 0, 1'b0, 0, 7);
        instr(O_OUT,  1'b0, 0, 1'b0, 0, 4);
        instr(O_NOP,  1'b0, 0, 1'b0, 0, 4);
        instr(O_HALT, 1'b0, 0, 1'b0, 4, 8);
        instr(5'b11111, 1'b0, 0, 1'b0, 0, 4);
        instr(O_ADD,  1'b0, 0, 1'b0, 0, 4);
        br_with_clear();
        for (int i = 0; i < 40; i++) rand_instr();

        // Instance with two memory wait states
        switch_to_b();
        instr(O_NOP,  1'b0, 0, 1'b0, 0, 6);
        instr(O_JAL,  1'b0, 0, 1'b0, 0, 7);
        instr(O_IN,   1'b0, 2, 1'b0, 0, 9);
        instr(O_BR,   1'b0, 0, 1'b1, 0, 9);
        instr(O_HALT, 1'b0, 0, 1'b0, 2, 8);
        halt_with_clear();
        for (int i = 0; i < 40; i++) rand_instr();

        noise(); step(F_T0);
        if (pending_len != 0) check("instr_len", 32'(len_seen), 32'(pending_len));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
